sram_read_control: RTL and testbench
====================================

SRAM_READ_CONTROL -- requirements
Module: sram_read_control

Interface
REQ-001 Parameter READ_LATENCY, 2: clk_100 cycles from address issue to the word being valid on data_from_sram; range 1..3.
REQ-002 Parameter FIFO_DEPTH, 4: number of 32-bit word entries in the internal buffer; SHALL be at least READ_LATENCY+1.
REQ-003 Clocking and reset: one clock, clk_100; reset rst is asynchronous and active-high.
REQ-004 clk_100  in  1  system clock; all logic on its rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 start  in  1  one-cycle request to begin a read burst; sampled only in IDLE.
REQ-007 base_addr  in  18  first SRAM word address of the burst; captured on accepted start.
REQ-008 word_count  in  18  number of 32-bit words to read; captured on accepted start.
REQ-009 data_from_sram  in  32  SRAM read data bus.
REQ-010 address_to_sram  out  18  SRAM word address.
REQ-011 chip_en  out  1  SRAM chip enable, active-low, constant 0.
REQ-012 output_en  out  1  SRAM output enable, active-low; 0 while busy, 1 otherwise.
REQ-013 write_en_n  out  1  SRAM write enable, active-low; constant 1 (this block never writes).
REQ-014 byte_en  out  4  SRAM byte enables, active-low, constant 4'b0000.
REQ-015 adv  out  1  SRAM address-valid strobe, constant 0.
REQ-016 pixel_data  out  8  unpacked pixel byte.
REQ-017 pixel_valid  out  1  pixel_data is valid.
REQ-018 pixel_ready  in  1  downstream accepts pixel_data; a transfer occurs when pixel_valid && pixel_ready.
REQ-019 busy  out  1  high from the cycle after an accepted start until done.
REQ-020 done  out  1  one-cycle pulse when the burst completes.

Function
REQ-021 FSM states: IDLE, READING, DRAINING, FINISH.
- IDLE to READING on start with word_count!=0.
- IDLE to FINISH on start with word_count==0; no SRAM reads are issued.
- READING to DRAINING after the last address is issued.
- DRAINING to FINISH after the last byte is transferred.
- FINISH to IDLE unconditionally.
REQ-022 A read issue is one address presented on address_to_sram for one cycle in READING. A read SHALL be issued only when outstanding_reads + fifo_count < FIFO_DEPTH, so the buffer never overflows.
REQ-023 The first issue occurs at base_addr in the cycle after the accepted start. Each subsequent issue increments the address by 1, modulo 2^18 (0x3FFFF wraps to 0x00000).
REQ-024 The word returned for an issue in cycle N SHALL be written into the FIFO at the clk_100 edge ending cycle N+READ_LATENCY, via an internal valid shift pipeline.
REQ-025 The head FIFO word is unpacked MSB first: [31:24], [23:16], [15:8], [7:0]. The word is popped after its 4th byte transfers.
REQ-026 With pixel_ready held high and no SRAM stall, one byte transfers per cycle. First pixel_valid occurs READ_LATENCY+1 cycles after the first issue.
REQ-027 pixel_valid SHALL be set only while a FIFO entry exists.
REQ-028 Under backpressure (pixel_valid=1, pixel_ready=0), pixel_data and pixel_valid are held stable and no byte is lost or duplicated.
REQ-029 A simultaneous FIFO push and pop in the same cycle SHALL keep fifo_count unchanged.
REQ-030 done SHALL pulse in FINISH, exactly once per accepted start. busy falls in the same cycle that done is high.
REQ-031 start while busy or in FINISH is ignored; captured parameters are unaffected.
REQ-032 Exactly 4*word_count bytes are transferred per burst.
REQ-033 address_to_sram holds its last value when not issuing; it is 0 after reset.

Reset
REQ-034 On rst asserted, at any time, all of the following take effect immediately:
- state=IDLE; address_to_sram=0; pixel_data=0; pixel_valid=0; busy=0; done=0; output_en=1.
- FIFO, outstanding count and byte index are cleared.
- In-flight read data is discarded.
REQ-035 After rst deasserts, the block waits for a fresh start; no partial burst resumes.

Verification
REQ-036 base_addr=0x00100, word_count=2, pixel_ready=1, SRAM model returns 0xA1B2C3D4 and 0x11223344 -> addresses 0x00100, 0x00101; bytes A1,B2,C3,D4,11,22,33,44 on consecutive cycles; one done pulse.
REQ-037 word_count=0 -> done pulses 2 cycles after start; pixel_valid never rises; output_en stays 1.
REQ-038 word_count=8, pixel_ready toggling randomly 30% high -> 32 bytes in order; fifo_count never exceeds 4; no address issued when outstanding+fifo_count=4.
REQ-039 base_addr=0x3FFFE, word_count=3 -> addresses 0x3FFFE, 0x3FFFF, 0x00000.
REQ-040 rst pulsed mid-burst after 5 bytes -> all outputs at reset values in the rst cycle; a new start with word_count=1 yields exactly 4 bytes from the new base_addr.
REQ-041 start re-pulsed while busy -> ignored; byte total and done count are unchanged.

Source files
------------

// File: rtl/sram_read_control.sv
// Burst reader for a pipelined SRAM: issues word reads under buffer flow control
// and streams each returned 32-bit word out as four bytes, MSB first.
module sram_read_control #(
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk_100,
  input  logic        rst,
  input  logic        start,
  input  logic [17:0] base_addr,
  input  logic [17:0] word_count,
  input  logic [31:0] data_from_sram,
  output logic [17:0] address_to_sram,
  output logic        chip_en,
  output logic        output_en,
  output logic        write_en_n,
  output logic [3:0]  byte_en,
  output logic        adv,
  output logic [7:0]  pixel_data,
  output logic        pixel_valid,
  input  logic        pixel_ready,
  output logic        busy,
  output logic        done
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + READ_LATENCY + 2);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] READING  = 2'd1;
  localparam logic [1:0] DRAINING = 2'd2;
  localparam logic [1:0] FINISH   = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [17:0]             addr_q, addr_d;
  logic                    issue_q, issue_d;
  logic [17:0]             issue_left_q, issue_left_d;
  logic [17:0]             pop_left_q, pop_left_d;
  logic [READ_LATENCY-1:0] pipe_q, pipe_d;
  logic [31:0]             fifo_mem_q [FIFO_DEPTH];
  logic [31:0]             fifo_mem_d [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           fifo_count_q, fifo_count_d;
  logic [1:0]              byte_idx_q, byte_idx_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    output_en_q, output_en_d;

  logic                    push_s, pop_s, xfer_s, can_issue_s, pix_valid_s;
  logic [CW-1:0]           outstanding_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  assign pix_valid_s = (fifo_count_q != {CW{1'b0}});

  // Next-state logic: FSM, issue flow control, read-return pipeline and FIFO bookkeeping.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    issue_d      = 1'b0;
    issue_left_d = issue_left_q;
    pop_left_d   = pop_left_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_count_d = fifo_count_q;
    byte_idx_d   = byte_idx_q;
    fifo_mem_d   = fifo_mem_q;

    // Returned data lands READ_LATENCY cycles after its issue cycle.
    pipe_d[0] = issue_q;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    push_s = pipe_q[READ_LATENCY-1];
    xfer_s = pix_valid_s && pixel_ready;
    pop_s  = xfer_s && (byte_idx_q == 2'd3);

    // Reads in flight include the one on the bus this cycle.
    outstanding_s = {{(CW-1){1'b0}}, issue_q};
    for (int i = 0; i < READ_LATENCY; i++) begin
      outstanding_s = outstanding_s + {{(CW-1){1'b0}}, pipe_q[i]};
    end
    can_issue_s = ((fifo_count_q + outstanding_s) < CW'(FIFO_DEPTH));

    if (push_s) begin
      fifo_mem_d[wr_ptr_q] = data_from_sram;
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d   = ptr_inc(rd_ptr_q);
      pop_left_d = pop_left_q - 18'd1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (xfer_s) begin
      byte_idx_d = byte_idx_q + 2'd1;
    end else begin
      byte_idx_d = byte_idx_q;
    end
    case ({push_s, pop_s})
      2'b10:   fifo_count_d = fifo_count_q + CW'(1);
      2'b01:   fifo_count_d = fifo_count_q - CW'(1);
      default: fifo_count_d = fifo_count_q;
    endcase

    case (state_q)
      IDLE: begin
        if (start && (word_count != 18'd0)) begin
          state_d      = READING;
          issue_d      = 1'b1;
          addr_d       = base_addr;
          issue_left_d = word_count - 18'd1;
          pop_left_d   = word_count;
        end else if (start) begin
          state_d = FINISH;
        end else begin
          state_d = IDLE;
        end
      end
      READING: begin
        if (issue_left_q == 18'd0) begin
          state_d = DRAINING;
        end else if (can_issue_s) begin
          issue_d      = 1'b1;
          addr_d       = addr_q + 18'd1;
          issue_left_d = issue_left_q - 18'd1;
        end else begin
          issue_d = 1'b0;
        end
      end
      DRAINING: begin
        if (pop_s && (pop_left_q == 18'd1)) begin
          state_d = FINISH;
        end else begin
          state_d = DRAINING;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d != IDLE);
    output_en_d = !((state_d == READING) || (state_d == DRAINING));
    done_d      = (state_q == FINISH);
  end

  // State registers; reset drops in-flight reads and empties the buffer.
  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= 18'd0;
      issue_q      <= 1'b0;
      issue_left_q <= 18'd0;
      pop_left_q   <= 18'd0;
      pipe_q       <= {READ_LATENCY{1'b0}};
      wr_ptr_q     <= {PW{1'b0}};
      rd_ptr_q     <= {PW{1'b0}};
      fifo_count_q <= {CW{1'b0}};
      byte_idx_q   <= 2'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      output_en_q  <= 1'b1;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= 32'd0;
      end
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      issue_q      <= issue_d;
      issue_left_q <= issue_left_d;
      pop_left_q   <= pop_left_d;
      pipe_q       <= pipe_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
      byte_idx_q   <= byte_idx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      output_en_q  <= output_en_d;
      fifo_mem_q   <= fifo_mem_d;
    end
  end

  // Head-word byte select, forced to zero whenever nothing is buffered.
  always_comb begin
    pixel_data = 8'd0;
    if (pix_valid_s) begin
      case (byte_idx_q)
        2'd0:    pixel_data = fifo_mem_q[rd_ptr_q][31:24];
        2'd1:    pixel_data = fifo_mem_q[rd_ptr_q][23:16];
        2'd2:    pixel_data = fifo_mem_q[rd_ptr_q][15:8];
        default: pixel_data = fifo_mem_q[rd_ptr_q][7:0];
      endcase
    end else begin
      pixel_data = 8'd0;
    end
  end

  assign pixel_valid     = pix_valid_s;
  assign address_to_sram = addr_q;
  assign chip_en         = 1'b0;
  assign write_en_n      = 1'b1;
  assign byte_en         = 4'b0000;
  assign adv             = 1'b0;
  assign output_en       = output_en_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_sram_read_control.sv
// Directed bench for sram_read_control with a fixed-latency SRAM model.
module tb_sram_read_control;
  localparam int LAT = 2;

  logic        clk_100 = 1'b0;
  logic        rst, start, pixel_ready;
  logic [17:0] base_addr, word_count, address_to_sram;
  logic [31:0] data_from_sram;
  logic        chip_en, output_en, write_en_n, adv, pixel_valid, busy, done;
  logic [3:0]  byte_en;
  logic [7:0]  pixel_data;

  int          total = 0;
  int          bad = 0;
  int          done_cnt = 0;
  logic [7:0]  got_q [$];
  logic [17:0] hist [0:2];

  sram_read_control #(.READ_LATENCY(LAT), .FIFO_DEPTH(4)) dut (
    .clk_100(clk_100), .rst(rst), .start(start), .base_addr(base_addr),
    .word_count(word_count), .data_from_sram(data_from_sram),
    .address_to_sram(address_to_sram), .chip_en(chip_en), .output_en(output_en),
    .write_en_n(write_en_n), .byte_en(byte_en), .adv(adv), .pixel_data(pixel_data),
    .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .busy(busy), .done(done)
  );

  always #5 clk_100 = ~clk_100;

  function automatic logic [31:0] mem_word(input logic [17:0] a);
    if (a == 18'h00100) return 32'hA1B2C3D4;
    if (a == 18'h00101) return 32'h11223344;
    return {8'h5A ^ a[7:0], a[7:0], 8'h3C, a[15:8]};
  endfunction

  function automatic logic [7:0] exp_byte(input logic [17:0] base, input int idx);
    logic [31:0] w;
    w = mem_word(base + 18'(idx / 4));
    case (idx % 4)
      0:       return w[31:24];
      1:       return w[23:16];
      2:       return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  // SRAM returns the word for the address seen LAT cycles earlier.
  assign data_from_sram = mem_word(hist[LAT-1]);

  always @(posedge clk_100) begin
    hist[0] <= address_to_sram;
    hist[1] <= hist[0];
    hist[2] <= hist[1];
    if (!rst && pixel_valid && pixel_ready) got_q.push_back(pixel_data);
    if (!rst && done) done_cnt <= done_cnt + 1;
  end

  task automatic start_burst(input logic [17:0] b, input logic [17:0] n);
    @(negedge clk_100);
    start = 1'b1; base_addr = b; word_count = n;
    @(negedge clk_100);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; pixel_ready = 1'b0; base_addr = 18'd0; word_count = 18'd0;
    repeat (3) @(negedge clk_100);
    total++; if (address_to_sram !== 18'd0) begin bad++; $display("FAIL rst_addr got=%h want=0", address_to_sram); end
    total++; if ({pixel_valid, pixel_data} !== 9'd0) begin bad++; $display("FAIL rst_pixel got=%b/%h want=0/00", pixel_valid, pixel_data); end
    total++; if ({busy, done, output_en} !== 3'b001) begin bad++; $display("FAIL rst_ctrl got=%b want=001", {busy, done, output_en}); end
    total++; if ({chip_en, write_en_n, byte_en, adv} !== 7'b0100000) begin bad++; $display("FAIL rst_const got=%b want=0100000", {chip_en, write_en_n, byte_en, adv}); end
    @(negedge clk_100); rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] exp8 [0:7] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h11, 8'h22, 8'h33, 8'h44};
    int d0 = done_cnt;
    pixel_ready = 1'b1;
    start_burst(18'h00100, 18'd2);
    total++; if (address_to_sram !== 18'h00100) begin bad++; $display("FAIL basic_addr0 got=%h want=00100", address_to_sram); end
    total++; if ({busy, output_en} !== 2'b10) begin bad++; $display("FAIL basic_busy got=%b want=10", {busy, output_en}); end
    @(negedge clk_100);
    total++; if (address_to_sram !== 18'h00101) begin bad++; $display("FAIL basic_addr1 got=%h want=00101", address_to_sram); end
    @(negedge clk_100);
    total++; if (pixel_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b want=0", pixel_valid); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_100);
      total++;
      if (pixel_valid !== 1'b1 || pixel_data !== exp8[i]) begin
        bad++; $display("FAIL basic_byte%0d got=%b/%h want=1/%h", i, pixel_valid, pixel_data, exp8[i]);
      end
    end
    @(negedge clk_100);
    total++; if ({done, busy, pixel_valid} !== 3'b010) begin bad++; $display("FAIL basic_finish got=%b want=010", {done, busy, pixel_valid}); end
    @(negedge clk_100);
    total++; if ({done, busy, output_en} !== 3'b101) begin bad++; $display("FAIL basic_done got=%b want=101", {done, busy, output_en}); end
    @(negedge clk_100);
    total++; if (done_cnt !== d0 + 1) begin bad++; $display("FAIL basic_done_cnt got=%0d want=%0d", done_cnt - d0, 1); end
  endtask

  task automatic test_zero();
    int d0 = done_cnt;
    got_q.delete();
    start_burst(18'h00040, 18'd0);
    total++; if ({done, busy, output_en, pixel_valid} !== 4'b0110) begin bad++; $display("FAIL zero_c1 got=%b want=0110", {done, busy, output_en, pixel_valid}); end
    @(negedge clk_100);
    total++; if ({done, busy, output_en, pixel_valid} !== 4'b1010) begin bad++; $display("FAIL zero_c2 got=%b want=1010", {done, busy, output_en, pixel_valid}); end
    repeat (3) @(negedge clk_100);
    total++; if (done_cnt !== d0 + 1 || got_q.size() != 0) begin bad++; $display("FAIL zero_totals got=%0d/%0d want=1/0", done_cnt - d0, got_q.size()); end
  endtask

  task automatic test_backpressure();
    int d0 = done_cnt;
    int stall_err = 0;
    int byte_err = 0;
    int fifo_max = 0;
    logic pv, pr;
    logic [7:0] pd;
    got_q.delete();
    start_burst(18'h02000, 18'd8);
    pv = 1'b0; pr = 1'b1; pd = 8'd0;
    for (int c = 0; c < 2000 && done_cnt == d0; c++) begin
      if (pv && !pr && (pixel_valid !== 1'b1 || pixel_data !== pd)) stall_err++;
      if (int'(dut.fifo_count_q) > fifo_max) fifo_max = int'(dut.fifo_count_q);
      pixel_ready = ($urandom_range(0, 9) < 3);
      pv = pixel_valid; pr = pixel_ready; pd = pixel_data;
      @(negedge clk_100);
    end
    pixel_ready = 1'b1;
    total++; if (done_cnt !== d0 + 1) begin bad++; $display("FAIL bp_done got=%0d want=1", done_cnt - d0); end
    total++; if (got_q.size() != 32) begin bad++; $display("FAIL bp_count got=%0d want=32", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 32; i++) if (got_q[i] !== exp_byte(18'h02000, i)) byte_err++;
    total++; if (byte_err != 0) begin bad++; $display("FAIL bp_bytes got=%0d wrong want=0", byte_err); end
    total++; if (stall_err != 0) begin bad++; $display("FAIL bp_hold got=%0d unstable want=0", stall_err); end
    total++; if (fifo_max > 4) begin bad++; $display("FAIL bp_fifo_max got=%0d want<=4", fifo_max); end
  endtask

  task automatic test_wrap();
    int d0 = done_cnt;
    int byte_err = 0;
    got_q.delete();
    pixel_ready = 1'b1;
    start_burst(18'h3FFFE, 18'd3);
    total++; if (address_to_sram !== 18'h3FFFE) begin bad++; $display("FAIL wrap_a0 got=%h want=3fffe", address_to_sram); end
    @(negedge clk_100);
    total++; if (address_to_sram !== 18'h3FFFF) begin bad++; $display("FAIL wrap_a1 got=%h want=3ffff", address_to_sram); end
    @(negedge clk_100);
    total++; if (address_to_sram !== 18'h00000) begin bad++; $display("FAIL wrap_a2 got=%h want=00000", address_to_sram); end
    for (int c = 0; c < 100 && done_cnt == d0; c++) @(negedge clk_100);
    for (int i = 0; i < got_q.size() && i < 12; i++) if (got_q[i] !== exp_byte(18'h3FFFE, i)) byte_err++;
    total++; if (got_q.size() != 12 || byte_err != 0) begin bad++; $display("FAIL wrap_bytes got=%0d/%0d want=12/0", got_q.size(), byte_err); end
  endtask

  task automatic test_reset_mid();
    int d0;
    got_q.delete();
    pixel_ready = 1'b1;
    start_burst(18'h01000, 18'd4);
    for (int c = 0; c < 100 && got_q.size() < 5; c++) @(negedge clk_100);
    rst = 1'b1;
    #1;
    total++; if (address_to_sram !== 18'd0 || {pixel_valid, pixel_data} !== 9'd0 || {busy, done, output_en} !== 3'b001) begin
      bad++; $display("FAIL mid_rst got=%h/%b/%h/%b want=0/0/00/001", address_to_sram, pixel_valid, pixel_data, {busy, done, output_en});
    end
    @(negedge clk_100); rst = 1'b0;
    repeat (4) @(negedge clk_100);
    total++; if ({busy, pixel_valid} !== 2'b00 || address_to_sram !== 18'd0) begin bad++; $display("FAIL mid_noresume got=%b/%h want=00/0", {busy, pixel_valid}, address_to_sram); end
    got_q.delete();
    d0 = done_cnt;
    start_burst(18'h00500, 18'd1);
    for (int c = 0; c < 100 && done_cnt == d0; c++) @(negedge clk_100);
    total++; if (got_q.size() != 4) begin bad++; $display("FAIL mid_count got=%0d want=4", got_q.size()); end
    else begin
      total++; if ({got_q[0], got_q[1], got_q[2], got_q[3]} !== mem_word(18'h00500)) begin
        bad++; $display("FAIL mid_word got=%h want=%h", {got_q[0], got_q[1], got_q[2], got_q[3]}, mem_word(18'h00500));
      end
    end
  endtask

  task automatic test_restart();
    int d0 = done_cnt;
    int byte_err = 0;
    got_q.delete();
    pixel_ready = 1'b1;
    start_burst(18'h00200, 18'd2);
    repeat (2) @(negedge clk_100);
    start = 1'b1; base_addr = 18'h00300; word_count = 18'd5;
    @(negedge clk_100);
    start = 1'b0;
    for (int c = 0; c < 100 && done_cnt == d0; c++) @(negedge clk_100);
    repeat (20) @(negedge clk_100);
    total++; if (done_cnt !== d0 + 1) begin bad++; $display("FAIL restart_done got=%0d want=1", done_cnt - d0); end
    for (int i = 0; i < got_q.size() && i < 8; i++) if (got_q[i] !== exp_byte(18'h00200, i)) byte_err++;
    total++; if (got_q.size() != 8 || byte_err != 0) begin bad++; $display("FAIL restart_bytes got=%0d/%0d want=8/0", got_q.size(), byte_err); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
